msg_streamer: RTL and testbench

Parametrised character sequencer driving the 8-bit display output of the chip top. It holds a small table of messages and streams the selected one, one character at a time, at a programmable rate. Modes are one-shot or loop. Each character is handed off with a valid/ready handshake so a downstream encoder or display mux can stall it. It sits between the input switches/control decode and `uo_out`, and replaces fixed single-character output logic.

---
 rtl/msg_streamer_pkg.sv | 42 ++++
 rtl/msg_dwell_cnt.sv | 41 ++++
 rtl/msg_streamer.sv | 184 ++++++++++++++++++
 tb/tb_msg_streamer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_streamer_pkg.sv
// msg_streamer_pkg: shared types, default sizes and the message ROM.
// The optional BLANK state exists only when MSG_STREAMER_BLANK_EN is defined.
package msg_streamer_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int MSG_LEN_DEF = 16;
    localparam int NUM_MSG_DEF = 4;
    localparam int DIV_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW,
        ST_NEXT,
`ifdef MSG_STREAMER_BLANK_EN
        ST_FIN,
        ST_BLANK
`else
        ST_FIN
`endif
    } state_t;

    // Message table. A message ends at its first 0x00 or at its last slot.
    // Message 2 fills every slot so the length limit is the terminator.
    function automatic logic [DATA_W_DEF-1:0] rom_char(input int unsigned sel,
                                                       input int unsigned idx);
        logic [8*MSG_LEN_DEF-1:0] row;
        case (sel)
            0:       row = {"T", {(MSG_LEN_DEF-1){8'h00}}};
            1:       row = {"TEC", {(MSG_LEN_DEF-3){8'h00}}};
            2:       row = "ABCDEFGHIJKLMNOP";
            default: row = '0;
        endcase
        if (idx >= MSG_LEN_DEF) begin
            return '0;
        end
        // Character 0 sits in the top byte; shift the wanted one up there.
        row = row << (8 * idx);
        return row[8*MSG_LEN_DEF-1 -: 8];
    endfunction

endpackage

// File: rtl/msg_dwell_cnt.sv
// msg_dwell_cnt: saturating dwell counter. Counts up to the live rate value
// and reports when the current character has been shown long enough.
module msg_dwell_cnt
    import msg_streamer_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] rate,
    output logic             at_rate
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stop at rate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && (cnt_q < rate)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count above a freshly lowered rate counts as reached.
    assign at_rate = (cnt_q >= rate);

endmodule

// File: rtl/msg_streamer.sv
// msg_streamer: streams one ROM message a character at a time with a
// programmable dwell and a valid/ready handshake. All outputs are registered.
// Build option MSG_STREAMER_BLANK_EN inserts a blank (0x00) character between
// message characters so repeated characters stay distinguishable.
module msg_streamer
    import msg_streamer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int NUM_MSG = NUM_MSG_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
    input  logic                       loop_mode,
    input  logic [DIV_W-1:0]           rate,
    input  logic                       ready,
    output logic [DATA_W-1:0]          data_out,
    output logic                       valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MSG_LEN)-1:0] index
);

    localparam int IDX_W = $clog2(MSG_LEN);
    localparam int SEL_W = $clog2(NUM_MSG);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               loop_q, loop_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W:0]     idx_inc;
    logic [DATA_W-1:0]  cur_char;
    logic               msg_more;
    logic               at_rate;
    logic               xfer;
    logic               cnt_clear;
    logic               cnt_inc;

    // ROM lookups for the current slot and the end-of-message test.
    always_comb begin
        idx_inc  = {1'b0, index_q} + 1'b1;
        cur_char = DATA_W'(rom_char(32'(sel_q), 32'(index_q)));
        msg_more = (32'(idx_inc) < MSG_LEN) &&
                   (rom_char(32'(sel_q), 32'(idx_inc)) != '0);
    end

    assign xfer = valid_q && ready && at_rate;

    // The counter restarts on entry to each shown character and only runs
    // while a character (or blank) is on display.
`ifdef MSG_STREAMER_BLANK_EN
    assign cnt_clear = en && ((state_q == ST_LOAD) || (state_q == ST_NEXT));
    assign cnt_inc   = en && ((state_q == ST_SHOW) || (state_q == ST_BLANK));
`else
    assign cnt_clear = en && ((state_q == ST_LOAD) || (state_q == ST_NEXT));
    assign cnt_inc   = en && (state_q == ST_SHOW);
`endif

    msg_dwell_cnt #(.DIV_W(DIV_W)) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .en      (cnt_inc),
        .rate    (rate),
        .at_rate (at_rate)
    );

    // Sequencer next-state and output decode; en low freezes everything.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        loop_d  = loop_q;
        index_d = index_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_d   = msg_sel;
                        loop_d  = loop_mode;
                        index_d = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    data_d = cur_char;
                    if ((cur_char == '0) && (index_q == '0)) begin
                        valid_d = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        valid_d = 1'b1;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (xfer) begin
                        valid_d = 1'b0;
                        state_d = ST_NEXT;
                    end
                end
`ifdef MSG_STREAMER_BLANK_EN
                ST_NEXT: begin
                    if (msg_more || loop_q) begin
                        data_d  = '0;
                        valid_d = 1'b1;
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
                ST_BLANK: begin
                    if (xfer) begin
                        valid_d = 1'b0;
                        index_d = msg_more ? idx_inc[IDX_W-1:0] : '0;
                        state_d = ST_LOAD;
                    end
                end
`else
                ST_NEXT: begin
                    if (msg_more) begin
                        index_d = idx_inc[IDX_W-1:0];
                        state_d = ST_LOAD;
                    end else if (loop_q) begin
                        index_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
`endif
                ST_FIN: begin
                    // Leave only once done has really been seen high; a pulse
                    // suppressed by en is re-issued on the next enabled cycle.
                    if (done_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = en && (state_d == ST_FIN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            loop_q  <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            loop_q  <= loop_d;
            index_q <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign index    = index_q;

endmodule

// File: tb/tb_msg_streamer.sv
// tb_msg_streamer: self-checking bench for msg_streamer. Expected values come
// from the message strings and the timing rules (rate+3 cycles per character,
// one extra cycle per stall after the dwell, done one cycle after the last NEXT).
module tb_msg_streamer;

    localparam int DATA_W  = 8;
    localparam int MSG_LEN = 16;
    localparam int NUM_MSG = 4;
    localparam int DIV_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              start;
    logic [1:0]        msg_sel;
    logic              loop_mode;
    logic [DIV_W-1:0]  rate;
    logic              ready;
    logic [7:0]        data_out;
    logic              valid;
    logic              busy;
    logic              done;
    logic [3:0]        index;

    int    n_cmp = 0;
    int    n_bad = 0;
    string msgs [4];

    always #5 clk = ~clk;

    msg_streamer #(
        .DATA_W(DATA_W), .MSG_LEN(MSG_LEN), .NUM_MSG(NUM_MSG), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .msg_sel(msg_sel),
        .loop_mode(loop_mode), .rate(rate), .ready(ready),
        .data_out(data_out), .valid(valid), .busy(busy), .done(done), .index(index)
    );

    // Issue a one-cycle start; returns at the sample point of cycle 1.
    task automatic start_msg(input int sel, input bit lp, input int r);
        @(negedge clk);
        msg_sel   = 2'(sel);
        loop_mode = lp;
        rate      = DIV_W'(r);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b0; msg_sel = '0;
        loop_mode = 1'b0; rate = '0; ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data_out, valid, busy, done, index} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset: got data=%h valid=%b busy=%b done=%b index=%0d, want all zero",
                     data_out, valid, busy, done, index);
        end
        rst = 1'b0;
        $display("reset: data=%h valid=%b busy=%b done=%b index=%0d", data_out, valid, busy, done, index);
    endtask

    // One-shot run with ready held high, checked cycle by cycle.
    task automatic test_timing(input int sel, input int r);
        int n, p, last, k, off;
        logic [7:0] ch;
        n = msgs[sel].len(); p = r + 3; last = 2 + n * p - 1;
        ready = 1'b1; en = 1'b1;
        start_msg(sel, 1'b0, r);
        for (int c = 1; c <= last + 1; c++) begin
            if (c >= 2 && c < last) begin
                k = (c - 2) / p; off = (c - 2) % p; ch = msgs[sel][k];
                n_cmp++;
                if (valid !== (off <= r)) begin
                    n_bad++;
                    $display("FAIL timing_valid msg%0d rate%0d cyc%0d: got %b want %b", sel, r, c, valid, off <= r);
                end
                if (off <= r) begin
                    n_cmp++;
                    if ({data_out, index} !== {ch, 4'(k)}) begin
                        n_bad++;
                        $display("FAIL timing_char msg%0d cyc%0d: got %h/%0d want %h/%0d", sel, c, data_out, index, ch, k);
                    end
                end
            end
            if (c == last) begin
                ch = msgs[sel][n-1];
                n_cmp++;
                if (data_out !== ch) begin
                    n_bad++;
                    $display("FAIL timing_fin_data msg%0d: got %h want %h", sel, data_out, ch);
                end
            end
            n_cmp++;
            if (done !== (c == last)) begin
                n_bad++;
                $display("FAIL timing_done msg%0d rate%0d cyc%0d: got %b want %b", sel, r, c, done, c == last);
            end
            n_cmp++;
            if (busy !== (c <= last)) begin
                n_bad++;
                $display("FAIL timing_busy msg%0d cyc%0d: got %b want %b", sel, c, busy, c <= last);
            end
            @(negedge clk);
        end
        $display("timing: msg%0d rate=%0d chars=%0d done_cycle=%0d", sel, r, n, last);
    endtask

    task automatic test_backpressure();
        int c;
        ready = 1'b1; en = 1'b1;
        start_msg(1, 1'b0, 0);
        for (c = 1; c <= 14; c++) begin
            if (c == 9 || c == 10) begin
                n_cmp++;
                if ({valid, data_out} !== {1'b1, 8'h54}) begin
                    n_bad++;
                    $display("FAIL bp_hold cyc%0d: got %b/%h want 1/54", c, valid, data_out);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if (valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_next cyc11: valid got %b want 0", valid);
                end
            end
            if (c == 13) begin
                n_cmp++;
                if ({valid, data_out} !== {1'b1, 8'h45}) begin
                    n_bad++;
                    $display("FAIL bp_second cyc13: got %b/%h want 1/45", valid, data_out);
                end
            end
            ready = !(c >= 2 && c <= 9);
            @(negedge clk);
        end
        while (busy === 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_timeout: busy got %b want 0", busy);
        end
        $display("backpressure: 8 stall cycles, run ended by cycle %0d", c);
    endtask

    task automatic test_empty();
        ready = 1'b1; en = 1'b1;
        start_msg(3, 1'b0, int'($urandom_range(3, 0)));
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({valid, busy, done} !== {1'b0, c <= 2, c == 2}) begin
                n_bad++;
                $display("FAIL empty cyc%0d: valid/busy/done got %b%b%b want 0%b%b", c, valid, busy, done, c <= 2, c == 2);
            end
            @(negedge clk);
        end
        $display("empty: msg3 done at cycle 2 without valid");
    endtask

    task automatic test_loop();
        int r, p, k;
        logic [7:0] ch;
        r = int'($urandom_range(3, 0)); p = r + 3;
        ready = 1'b1; en = 1'b1;
        start_msg(1, 1'b1, r);
        for (int c = 1; c <= 2 + 7 * p; c++) begin
            if (c >= 2 && (c - 2) % p == 0) begin
                k = (c - 2) / p; ch = msgs[1][k % 3];
                n_cmp++;
                if ({valid, data_out, index} !== {1'b1, ch, 4'(k % 3)}) begin
                    n_bad++;
                    $display("FAIL loop_char %0d: got %b/%h/%0d want 1/%h/%0d", k, valid, data_out, index, ch, k % 3);
                end
            end
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL loop_done cyc%0d: got %b want 0", c, done);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({data_out, valid, busy, done, index} !== 15'd0) begin
            n_bad++;
            $display("FAIL loop_reset: got data=%h valid=%b busy=%b index=%0d want zeros", data_out, valid, busy, index);
        end
        $display("loop: rate=%0d, 7 characters wrapped, stopped by reset", r);
    endtask

    task automatic test_enable();
        logic [14:0] snap;
        logic [7:0]  ch;
        ready = 1'b1; en = 1'b1;
        start_msg(1, 1'b0, 2);
        for (int c = 1; c <= 22; c++) begin
            if (c == 3) begin
                snap = {data_out, valid, busy, done, index};
                n_cmp++;
                if (snap !== {8'h54, 1'b1, 1'b1, 1'b0, 4'd0}) begin
                    n_bad++;
                    $display("FAIL en_pre: got %h want %h", snap, {8'h54, 1'b1, 1'b1, 1'b0, 4'd0});
                end
            end
            if (c >= 4 && c <= 8) begin
                n_cmp++;
                if ({data_out, valid, busy, done, index} !== snap) begin
                    n_bad++;
                    $display("FAIL en_frozen cyc%0d: got %h want %h", c, {data_out, valid, busy, done, index}, snap);
                end
            end
            if (c == 12 || c == 17) begin
                ch = msgs[1][(c - 7) / 5];
                n_cmp++;
                if ({valid, data_out} !== {1'b1, ch}) begin
                    n_bad++;
                    $display("FAIL en_resume cyc%0d: got %b/%h want 1/%h", c, valid, data_out, ch);
                end
            end
            if (c >= 9) begin
                n_cmp++;
                if ({done, busy} !== {c == 21, c <= 21}) begin
                    n_bad++;
                    $display("FAIL en_done cyc%0d: done/busy got %b%b want %b%b", c, done, busy, c == 21, c <= 21);
                end
            end
            en = !(c >= 3 && c <= 7);
            @(negedge clk);
        end
        $display("enable: 5-cycle freeze mid-character, done moved to cycle 21");
    endtask

    task automatic test_reset_mid();
        ready = 1'b1; en = 1'b1;
        start_msg(2, 1'b0, 0);
        for (int c = 1; c <= 6; c++) begin
            if (c == 5) begin
                n_cmp++;
                if ({valid, data_out} !== {1'b1, 8'h42}) begin
                    n_bad++;
                    $display("FAIL rstmid_pre: got %b/%h want 1/42", valid, data_out);
                end
            end
            rst = (c == 6);
            @(negedge clk);
        end
        rst = 1'b0;
        n_cmp++;
        if ({data_out, valid, busy, done, index} !== 15'd0) begin
            n_bad++;
            $display("FAIL rstmid: got data=%h valid=%b busy=%b done=%b index=%0d want zeros",
                     data_out, valid, busy, done, index);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_idle: busy got %b want 0", busy);
        end
        $display("reset_mid: reset at cycle 6 of msg2 returned outputs to zero");
    endtask

    // Random messages, rates and ready; a scoreboard tracks which characters
    // have been handed off and when the next transfer must happen.
    task automatic test_random_stream();
        for (int run = 0; run < 8; run++) begin
            int sel, r, n, pos, show, cyc;
            bit pend, pvalid, seen_done;
            logic [7:0] pdata, ch;
            sel = int'($urandom_range(2, 0)); r = int'($urandom_range(3, 0));
            n = msgs[sel].len();
            pos = 0; show = 0; cyc = 0; pend = 0; pvalid = 0; seen_done = 0; pdata = '0;
            en = 1'b1; ready = 1'b1;
            start_msg(sel, 1'b0, r);
            while (!seen_done && cyc < 400) begin
                if (pend) begin
                    n_cmp++;
                    if (valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL rnd_xfer run%0d char%0d: valid got %b want 0", run, pos, valid);
                    end
                    pos++; pend = 0;
                end else if (pvalid) begin
                    n_cmp++;
                    if ({valid, data_out} !== {1'b1, pdata}) begin
                        n_bad++;
                        $display("FAIL rnd_hold run%0d: got %b/%h want 1/%h", run, valid, data_out, pdata);
                    end
                end
                if (valid === 1'b1) begin
                    if (show == 0) begin
                        ch = (pos < n) ? msgs[sel][pos] : 8'h00;
                        n_cmp++;
                        if (pos >= n || {data_out, index} !== {ch, 4'(pos)}) begin
                            n_bad++;
                            $display("FAIL rnd_char run%0d pos%0d: got %h/%0d want %h/%0d", run, pos, data_out, index, ch, pos);
                        end
                    end
                    show++;
                end else begin
                    show = 0;
                end
                if (done === 1'b1) begin
                    seen_done = 1;
                    n_cmp++;
                    if (pos != n) begin
                        n_bad++;
                        $display("FAIL rnd_done run%0d: chars sent got %0d want %0d", run, pos, n);
                    end
                end
                pvalid = (valid === 1'b1); pdata = data_out;
                ready = ($urandom_range(3, 0) != 0);
                if (valid === 1'b1 && ready && show >= r + 1) pend = 1;
                @(negedge clk);
                cyc++;
            end
            n_cmp++;
            if (!seen_done || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_end run%0d: done_seen=%0d busy=%b want 1/0", run, seen_done, busy);
            end
            $display("random run%0d: msg%0d rate=%0d chars=%0d cycles=%0d", run, sel, r, pos, cyc);
        end
    endtask

    initial begin
        msgs[0] = "T";
        msgs[1] = "TEC";
        msgs[2] = "ABCDEFGHIJKLMNOP";
        msgs[3] = "";
        test_reset();
        test_timing(1, 0);
        test_timing(1, 3);
        test_timing(2, int'($urandom_range(3, 0)));
        test_timing(0, int'($urandom_range(3, 0)));
        test_backpressure();
        test_empty();
        test_loop();
        test_enable();
        test_reset_mid();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
